// File: rtl/sap2_pkg.sv
// Shared types for the SAP-2 core: opcode and controller state encodings.
// Imported by the core and the RAM.
package sap2_pkg;

  localparam int OPC_WIDTH = 4;

  typedef enum logic [OPC_WIDTH-1:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_JMP = 4'h4,
    OP_JZ  = 4'h5,
    OP_JC  = 4'h6,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_PROG,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    S_HALT
  } state_t;

endpackage

// File: rtl/sap2_ram.sv
// Program/data RAM for the SAP-2 core.
// Synchronous write, combinational read, contents never reset.
module sap2_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap2_core.sv
// SAP-2 CPU core: PC, MAR, IR, A/B, adder/subtractor, Z/C flags, RAM and a
// six-T-state controller with program-load and halt states.
module sap2_core
  import sap2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  prog_mode,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  halted
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic                  z_flag;
  logic                  c_flag;

  opcode_t               opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [DATA_WIDTH:0]   alu_sum;
  logic                  alu_zero;
  logic                  alu_carry;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign opcode  = opcode_t'(ir[DATA_WIDTH-1 -: OPC_WIDTH]);
  assign operand = ir[ADDR_WIDTH-1:0];
  assign halted  = (state == S_HALT);

  // For SUB the extra MSB is a borrow, so the carry flag is its inverse.
  always_comb begin
    if (opcode == OP_SUB) begin
      alu_sum   = {1'b0, a_reg} - {1'b0, b_reg};
      alu_carry = ~alu_sum[DATA_WIDTH];
    end else begin
      alu_sum   = {1'b0, a_reg} + {1'b0, b_reg};
      alu_carry = alu_sum[DATA_WIDTH];
    end
    alu_zero = (alu_sum[DATA_WIDTH-1:0] == '0);
  end

  // The host owns the write port while loading; otherwise only STA writes.
  always_comb begin
    if (state == S_PROG) begin
      ram_we    = prog_we;
      ram_waddr = prog_addr;
      ram_wdata = prog_data;
    end else begin
      ram_we    = (state == T5) && (opcode == OP_STA) && !prog_mode;
      ram_waddr = mar;
      ram_wdata = a_reg;
    end
  end

  sap2_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(mar),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= T1;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (prog_mode) begin
      state_next = S_PROG;
    end else begin
      case (state)
        S_PROG: state_next = T1;
        T1:     state_next = T2;
        T2:     state_next = T3;
        T3:     state_next = T4;
        T4:     state_next = (opcode == OP_HLT) ? S_HALT : T5;
        T5:     state_next = T6;
        T6:     state_next = T1;
        S_HALT: state_next = S_HALT;
      endcase
    end
  end

  // prog_mode outranks everything, so an instruction in flight is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (prog_mode) begin
        pc     <= '0;
        a_reg  <= '0;
        b_reg  <= '0;
        z_flag <= 1'b0;
        c_flag <= 1'b0;
      end else begin
        case (state)
          T1: mar <= pc;
          T2: pc  <= pc + ADDR_WIDTH'(1);
          T3: ir  <= ram_rdata;
          T4: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
              OP_JMP: pc <= operand;
              OP_JZ: begin
                if (z_flag) pc <= operand;
              end
              OP_JC: begin
                if (c_flag) pc <= operand;
              end
              OP_OUT: begin
                out_data  <= a_reg;
                out_valid <= 1'b1;
              end
              default: ;
            endcase
          end
          T5: begin
            if (opcode == OP_LDA) begin
              a_reg <= ram_rdata;
            end else if (opcode == OP_ADD || opcode == OP_SUB) begin
              b_reg <= ram_rdata;
            end
          end
          T6: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
              a_reg  <= alu_sum[DATA_WIDTH-1:0];
              z_flag <= alu_zero;
              c_flag <= alu_carry;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sap2_core.sv
// Bench for sap2_core: directed and random programs, each checked cycle by
// cycle against an instruction-level reference model.
module tb_sap2_core;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = 640;

  logic          clock = 1'b0;
  logic          reset;
  logic          prog_mode;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          halted;

  int vectors     = 0;
  int miscompares = 0;

  int image   [DEPTH];
  int ref_mem [DEPTH];
  int exp_valid [0:MAXC];
  int exp_data  [0:MAXC];
  int exp_halt  [0:MAXC];
  int ref_out = 0;
  int ref_a, ref_z, ref_c;
  int op_table [10] = '{0, 1, 2, 3, 4, 5, 6, 14, 15, 7};

  sap2_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .prog_mode(prog_mode),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .halted   (halted)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int cyc, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s@%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < DEPTH; i++) image[i] = 0;
  endtask

  // Instruction-at-a-time reference: each instruction spans six edges, OUT and
  // HLT take effect on the fourth edge of their instruction.
  task automatic run_model(input int ncyc);
    int pc, a, b, z, c, word, op, opnd, s, base;
    int modv;
    modv = 1 << DW;
    pc = 0; a = 0; b = 0; z = 0; c = 0; base = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = image[i];
    for (int e = 0; e <= ncyc; e++) begin
      exp_valid[e] = 0;
      exp_halt[e]  = 0;
      exp_data[e]  = ref_out;
    end
    while (base + 6 <= ncyc) begin
      word = ref_mem[pc];
      pc   = (pc + 1) % DEPTH;
      op   = word >> (DW - 4);
      opnd = word % DEPTH;
      case (op)
        0: a = ref_mem[opnd];
        1: begin
          b = ref_mem[opnd]; s = a + b;
          c = (s >= modv) ? 1 : 0; a = s % modv; z = (a == 0) ? 1 : 0;
        end
        2: begin
          b = ref_mem[opnd];
          c = (a >= b) ? 1 : 0; a = (a - b + modv) % modv; z = (a == 0) ? 1 : 0;
        end
        3: ref_mem[opnd] = a;
        4: pc = opnd;
        5: if (z != 0) pc = opnd;
        6: if (c != 0) pc = opnd;
        14: begin
          ref_out = a;
          exp_valid[base + 4] = 1;
          for (int e = base + 4; e <= ncyc; e++) exp_data[e] = a;
        end
        15: begin
          for (int e = base + 4; e <= ncyc; e++) exp_halt[e] = 1;
          break;
        end
        default: ;
      endcase
      base += 6;
    end
    ref_a = a; ref_z = z; ref_c = c;
  endtask

  // Leaves prog_mode low just before the edge that counts as cycle 0.
  task automatic load_program();
    @(negedge clock);
    prog_mode = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = DW'(image[i]);
    end
    @(negedge clock);
    prog_we   = 1'b0;
    prog_mode = 1'b0;
  endtask

  task automatic run_checked(input int ncyc, input string tag, input bit from_prog,
                             input bit noise);
    run_model(ncyc);
    if (from_prog) @(posedge clock);
    for (int e = 1; e <= ncyc; e++) begin
      @(posedge clock);
      #1;
      check({tag, ".valid"}, e, 32'(out_valid), 32'(exp_valid[e]));
      check({tag, ".data"}, e, 32'(out_data), 32'(exp_data[e]));
      check({tag, ".halted"}, e, 32'(halted), 32'(exp_halt[e]));
      if (noise) begin
        prog_we   = 1'($urandom_range(0, 1));
        prog_addr = AW'($urandom);
        prog_data = DW'($urandom);
      end
    end
    prog_we = 1'b0;
    for (int i = 0; i < DEPTH; i++) check({tag, ".mem"}, i, 32'(dut.u_ram.mem[i]), 32'(ref_mem[i]));
    check({tag, ".a"}, ncyc, 32'(dut.a_reg), 32'(ref_a));
    check({tag, ".z"}, ncyc, 32'(dut.z_flag), 32'(ref_z));
    check({tag, ".c"}, ncyc, 32'(dut.c_flag), 32'(ref_c));
  endtask

  task automatic applyStimulus_plan1();
    clear_image();
    image[0] = 'h09; image[1] = 'h1A; image[2] = 'hE0; image[3] = 'hF0;
    image[9] = 'h05; image[10] = 'h03;
  endtask

  initial begin
    reset = 1'b1; prog_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #1;
    check("rst.out_data", 0, 32'(out_data), 32'h0);
    check("rst.out_valid", 0, 32'(out_valid), 32'h0);
    check("rst.halted", 0, 32'(halted), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus_plan1();
    load_program();
    run_checked(36, "p1", 1'b1, 1'b0);
    check("p1.out_const", 36, 32'(out_data), 32'h08);
    check("p1.halt_const", 36, 32'(halted), 32'h1);

    clear_image();
    image[0] = 'h09; image[1] = 'h2A; image[2] = 'h55; image[3] = 'hF0;
    image[5] = 'hE0; image[6] = 'hF0; image[9] = 'h07; image[10] = 'h07;
    load_program();
    run_checked(48, "p2", 1'b1, 1'b0);
    check("p2.z_const", 48, 32'(dut.z_flag), 32'h1);
    check("p2.c_const", 48, 32'(dut.c_flag), 32'h1);

    clear_image();
    image[0] = 'h09; image[1] = 'h1A; image[2] = 'h65; image[3] = 'hF0;
    image[5] = 'hE0; image[6] = 'hF0; image[9] = 'hFF; image[10] = 'h01;
    load_program();
    run_checked(48, "p3a", 1'b1, 1'b0);
    check("p3a.a_const", 48, 32'(dut.a_reg), 32'h0);
    check("p3a.c_const", 48, 32'(dut.c_flag), 32'h1);
    image[9] = 'h01;
    load_program();
    run_checked(48, "p3b", 1'b1, 1'b0);

    clear_image();
    image[0] = 'h09; image[1] = 'h3F; image[2] = 'h08; image[3] = 'h0F;
    image[4] = 'hE0; image[5] = 'hF0; image[8] = 'h00; image[9] = 'h5A;
    load_program();
    run_checked(48, "p4", 1'b1, 1'b0);
    check("p4.out_const", 48, 32'(out_data), 32'h5A);
    check("p4.memF_const", 48, 32'(dut.u_ram.mem[15]), 32'h5A);

    for (int i = 0; i < DEPTH; i++) image[i] = 'h70;
    image[0] = 'hE0;
    load_program();
    run_checked(288, "p5", 1'b1, 1'b0);

    // Reset while the ADD of plan 1 sits in T5, then rerun with write noise.
    applyStimulus_plan1();
    load_program();
    repeat (11) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("p6.a", 0, 32'(dut.a_reg), 32'h0);
    check("p6.b", 0, 32'(dut.b_reg), 32'h0);
    check("p6.z", 0, 32'(dut.z_flag), 32'h0);
    check("p6.c", 0, 32'(dut.c_flag), 32'h0);
    check("p6.out_data", 0, 32'(out_data), 32'h0);
    check("p6.out_valid", 0, 32'(out_valid), 32'h0);
    check("p6.halted", 0, 32'(halted), 32'h0);
    @(negedge clock);
    reset   = 1'b0;
    ref_out = 0;
    run_checked(36, "p6", 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 3) == 0) image[i] = int'($urandom_range(0, 255));
        else image[i] = op_table[$urandom_range(0, 9)] * 16 + int'($urandom_range(0, 15));
      end
      load_program();
      run_checked(240, "rnd", 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sap2_core.md
Name: sap2_core

Overview:
- Parametrised successor to the fixed 8-bit SAP-1 datapath.
- Contains the PC, MAR, IR, accumulator A, B register, adder/subtractor, Z/C flags, program RAM and the T-state controller in one block.
- Adds configurable data and address widths, a program-load port, a store instruction (STA), jumps (JMP/JZ/JC), a halt state and a validated output strobe.
- Sits as the CPU core under the board-level top; the host loads RAM through the program port, then releases the core to run.

Parameters:
DATA_WIDTH, 8, width of RAM words, A, B, ALU and out_data; must be >= ADDR_WIDTH + 4
ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH; also the width of PC and MAR

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
prog_mode  in  1  high = core held in program-load state
prog_we  in  1  RAM write strobe, honoured only in S_PROG
prog_addr  in  ADDR_WIDTH  RAM write address
prog_data  in  DATA_WIDTH  RAM write data
out_data  out  DATA_WIDTH  output register
out_valid  out  1  one-cycle pulse when out_data is updated
halted  out  1  high while in S_HALT

Behaviour:
- Instruction word format:
  - opcode = word[DATA_WIDTH-1 -: 4]
  - operand = word[ADDR_WIDTH-1:0]
  - other bits are ignored.
- Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 JMP, 5 JZ, 6 JC, E OUT, F HLT. All other opcodes are NOP.
- RAM: synchronous write, combinational read, not reset.
  - The write port is shared: prog_* in S_PROG, STA otherwise.
- Reset (async): PC, MAR, IR, A, B, Z, C, out_data = 0; out_valid = 0; halted = 0. Next state after reset:
  - S_PROG if prog_mode = 1;
  - otherwise T1.
- States: S_PROG, T1..T6, S_HALT.
  - Every instruction takes exactly 6 cycles, T1 through T6; T6 returns to T1.
- prog_mode = 1 sampled at any edge forces S_PROG from any state, aborting the current instruction.
  - On entering S_PROG: PC, A, B, Z, C = 0 and halted = 0.
  - When prog_mode falls, the next state is T1 with PC = 0.
- Fetch:
  - T1: MAR <= PC.
  - T2: PC <= PC + 1, mod 2**ADDR_WIDTH (wraps).
  - T3: IR <= RAM[MAR].
- Execute (states not listed are idle):
  - LDA: T4 MAR <= operand; T5 A <= RAM[MAR].
  - ADD/SUB: T4 MAR <= operand; T5 B <= RAM[MAR]; T6 A <= A ± B.
    - Z = (result == 0).
    - C = carry-out for ADD; C = no-borrow (A >= B, unsigned) for SUB.
  - STA: T4 MAR <= operand; T5 RAM[MAR] <= A. Self-modifying code is legal; the new value takes effect on the next fetch.
  - JMP: T4 PC <= operand.
  - JZ / JC: T4 PC <= operand if Z / C is 1; otherwise no change.
  - OUT: T4 out_data <= A and out_valid <= 1. out_valid is forced back to 0 on the next edge, so it is high for exactly one cycle. out_data holds until the next OUT or reset.
  - HLT: T4 goes to S_HALT. halted = 1 for as long as the core stays there.
    - Only reset or prog_mode leaves S_HALT.
    - No registers change while halted.
- Flags change only on ADD/SUB.
- prog_we outside S_PROG is ignored.
- Reset asserted mid-instruction aborts it. RAM keeps its contents; the core restarts at PC = 0.

Decomposition:
- sap2_pkg:
  - opcode enum (4-bit)
  - state enum (S_PROG, T1..T6, S_HALT)
  - OPC_WIDTH = 4 constant
- One sub-module, sap2_ram:
  - parameters DATA_WIDTH, ADDR_WIDTH
  - ports: clock, we, waddr, wdata, raddr, rdata (combinational read)
  - the write-source mux lives in sap2_core.

Test Plan:
1. Load program, then drop prog_mode; call that edge cycle 0:
   - 0:0x09 LDA 9, 1:0x1A ADD A, 2:0xE0 OUT, 3:0xF0 HLT, 9:0x05, A:0x03.
   - Required: out_valid high only in cycle 16, with out_data = 0x08.
   - Required: halted rises at cycle 22 and stays high; Z = 0, C = 0.
2. SUB to zero and branch:
   - 0:LDA 9, 1:SUB A, 2:JZ 5, 3:HLT, 5:OUT, 6:HLT, with 9 = A = 0x07.
   - Required: Z = 1, C = 1, branch taken, one out_valid with out_data = 0x00, then halted.
3. ADD overflow and JC:
   - 0xFF + 0x01.
   - Required: A = 0x00, Z = 1, C = 1; JC 5 taken.
   - Repeat with 0x01 + 0x01: JC not taken, execution falls through to the next PC.
4. STA round-trip:
   - LDA 9 (0x5A), STA F, LDA 8 (0x00), LDA F, OUT.
   - Required: out_data = 0x5A; RAM[F] = 0x5A read back after the run.
5. PC wrap:
   - All 16 words NOP (0x70) except 0:0xE0 OUT, with A = 0.
   - Required: out_valid pulses every 96 cycles; PC goes 15 -> 0 with no stall.
6. Reset mid-ADD, asserted in T5:
   - Required immediately (before the next clock): A, B, Z, C, out_data = 0, out_valid = 0, halted = 0.
   - RAM unchanged; after reset release, the first fetch is from address 0.
   - Also check that prog_we pulses while running leave RAM unmodified.
